// File: rtl/muldiv_iter_pkg.sv
// Shared encodings for the iterative RV32M multiply/divide unit.
// Holds the funct7/funct3 decode values, the FSM states and the operand-signedness helpers.
package muldiv_iter_pkg;

    localparam logic [6:0] FUNCT7_MULDIV = 7'b0000001;

    localparam logic [2:0] FUNCT3_MUL    = 3'b000;
    localparam logic [2:0] FUNCT3_MULH   = 3'b001;
    localparam logic [2:0] FUNCT3_MULHSU = 3'b010;
    localparam logic [2:0] FUNCT3_MULHU  = 3'b011;
    localparam logic [2:0] FUNCT3_DIV    = 3'b100;
    localparam logic [2:0] FUNCT3_DIVU   = 3'b101;
    localparam logic [2:0] FUNCT3_REM    = 3'b110;
    localparam logic [2:0] FUNCT3_REMU   = 3'b111;

    typedef enum logic [1:0] {
        MD_IDLE = 2'd0,
        MD_CALC = 2'd1,
        MD_DONE = 2'd2
    } md_state_e;

    function automatic logic rs1_is_signed(input logic [2:0] f);
        return (f == FUNCT3_MULH) || (f == FUNCT3_MULHSU) ||
               (f == FUNCT3_DIV)  || (f == FUNCT3_REM);
    endfunction

    function automatic logic rs2_is_signed(input logic [2:0] f);
        return (f == FUNCT3_MULH) || (f == FUNCT3_DIV) || (f == FUNCT3_REM);
    endfunction

endpackage

// File: rtl/muldiv_step.sv
// Combinational core: BITS_PER_CYCLE shift-add (multiply) or restoring (divide) sub-steps.
// {hi,lo} is the product accumulator for multiply, or {remainder, dividend/quotient} for divide.
module muldiv_step #(
    parameter int XLEN           = 32,
    parameter int BITS_PER_CYCLE = 1
) (
    input  logic            op_div,
    input  logic [XLEN-1:0] hi_i,
    input  logic [XLEN-1:0] lo_i,
    input  logic [XLEN-1:0] opnd_i,
    output logic [XLEN-1:0] hi_o,
    output logic [XLEN-1:0] lo_o
);

    logic [XLEN-1:0] hi;
    logic [XLEN-1:0] lo;
    logic [XLEN:0]   sum;
    logic [XLEN:0]   rem_sh;
    logic            fits;

    always_comb begin
        hi     = hi_i;
        lo     = lo_i;
        sum    = '0;
        rem_sh = '0;
        fits   = 1'b0;
        for (int i = 0; i < BITS_PER_CYCLE; i++) begin
            if (op_div) begin
                // Partial remainder stays below the divisor, so the difference fits in XLEN bits.
                rem_sh = {hi, lo[XLEN-1]};
                fits   = (rem_sh >= {1'b0, opnd_i});
                hi     = fits ? (rem_sh[XLEN-1:0] - opnd_i) : rem_sh[XLEN-1:0];
                lo     = {lo[XLEN-2:0], fits};
            end else begin
                sum = {1'b0, hi} + (lo[0] ? {1'b0, opnd_i} : {(XLEN+1){1'b0}});
                hi  = sum[XLEN:1];
                lo  = {sum[0], lo[XLEN-1:1]};
            end
        end
        hi_o = hi;
        lo_o = lo;
    end

endmodule

// File: rtl/muldiv_iter.sv
// Iterative RV32M multiply/divide unit: captures magnitudes, iterates N cycles, sign-corrects.
// Division-by-zero and signed-overflow cases bypass iteration and finish one edge after acceptance.
module muldiv_iter
    import muldiv_iter_pkg::*;
#(
    parameter int XLEN           = 32,
    parameter int BITS_PER_CYCLE = 1
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            start,
    input  logic            kill,
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] rs1,
    input  logic [XLEN-1:0] rs2,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result
);

    localparam int N     = XLEN / BITS_PER_CYCLE;
    localparam int CNT_W = (N > 1) ? $clog2(N) : 1;
    localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

    md_state_e        state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [XLEN-1:0]  hi_q, hi_d;
    logic [XLEN-1:0]  lo_q, lo_d;
    logic [XLEN-1:0]  opnd_q, opnd_d;
    logic [2:0]       op_q, op_d;
    logic             neg_q, neg_d;
    logic [XLEN-1:0]  result_q, result_d;

    logic            neg1, neg2;
    logic [XLEN-1:0] mag1, mag2;
    logic            is_div, is_rem, div_zero, div_ovf, is_special, res_neg;
    logic [XLEN-1:0] special_res;

    assign neg1 = rs1_is_signed(funct3) & rs1[XLEN-1];
    assign neg2 = rs2_is_signed(funct3) & rs2[XLEN-1];
    assign mag1 = neg1 ? (~rs1 + 1'b1) : rs1;
    assign mag2 = neg2 ? (~rs2 + 1'b1) : rs2;

    assign is_div     = funct3[2];
    assign is_rem     = funct3[2] & funct3[1];
    assign div_zero   = is_div && (rs2 == '0);
    assign div_ovf    = ((funct3 == FUNCT3_DIV) || (funct3 == FUNCT3_REM)) &&
                        (rs1 == MIN_NEG) && (rs2 == '1);
    assign is_special = div_zero | div_ovf;
    assign res_neg    = is_rem ? neg1 : (neg1 ^ neg2);

    always_comb begin
        special_res = '0;
        if (div_zero) begin
            special_res = is_rem ? rs1 : '1;
        end else if (div_ovf) begin
            special_res = is_rem ? '0 : rs1;
        end
    end

    logic [XLEN-1:0]   step_hi, step_lo;
    logic [2*XLEN-1:0] prod, prod_fix;
    logic [XLEN-1:0]   quo_fix, rem_fix, final_res;

    muldiv_step #(
        .XLEN           (XLEN),
        .BITS_PER_CYCLE (BITS_PER_CYCLE)
    ) u_step (
        .op_div (op_q[2]),
        .hi_i   (hi_q),
        .lo_i   (lo_q),
        .opnd_i (opnd_q),
        .hi_o   (step_hi),
        .lo_o   (step_lo)
    );

    // Negation is applied to the full double-width product so MULH* sees correct borrows.
    assign prod     = {step_hi, step_lo};
    assign prod_fix = neg_q ? (~prod + 1'b1) : prod;
    assign quo_fix  = neg_q ? (~step_lo + 1'b1) : step_lo;
    assign rem_fix  = neg_q ? (~step_hi + 1'b1) : step_hi;

    always_comb begin
        final_res = '0;
        case (op_q)
            FUNCT3_MUL:                              final_res = prod_fix[XLEN-1:0];
            FUNCT3_MULH, FUNCT3_MULHSU, FUNCT3_MULHU: final_res = prod_fix[2*XLEN-1:XLEN];
            FUNCT3_DIV, FUNCT3_DIVU:                 final_res = quo_fix;
            default:                                 final_res = rem_fix;
        endcase
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        opnd_d   = opnd_q;
        op_d     = op_q;
        neg_d    = neg_q;
        result_d = result_q;
        case (state_q)
            MD_IDLE, MD_DONE: begin
                state_d = MD_IDLE;
                if (start && !kill) begin
                    op_d   = funct3;
                    neg_d  = res_neg;
                    cnt_d  = '0;
                    hi_d   = '0;
                    opnd_d = is_div ? mag2 : mag1;
                    lo_d   = is_div ? mag1 : mag2;
                    if (is_special) begin
                        state_d  = MD_DONE;
                        result_d = special_res;
                    end else begin
                        state_d = MD_CALC;
                    end
                end
            end
            MD_CALC: begin
                if (kill) begin
                    state_d = MD_IDLE;
                end else begin
                    hi_d = step_hi;
                    lo_d = step_lo;
                    if (cnt_q == CNT_W'(N - 1)) begin
                        state_d  = MD_DONE;
                        result_d = final_res;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            default: state_d = MD_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q  <= MD_IDLE;
            cnt_q    <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
            opnd_q   <= '0;
            op_q     <= '0;
            neg_q    <= 1'b0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            opnd_q   <= opnd_d;
            op_q     <= op_d;
            neg_q    <= neg_d;
            result_q <= result_d;
        end
    end

    assign busy   = (state_q == MD_CALC);
    assign done   = (state_q == MD_DONE);
    assign result = result_q;

endmodule

// File: tb/tb_muldiv_iter.sv
// Bench for muldiv_iter: a 32-bit/1-bit-per-cycle and a 16-bit/4-bit-per-cycle instance share stimulus
// and are each checked against an arithmetic reference model for result, latency and busy duration.
module tb_muldiv_iter;

    localparam int NA = 32;
    localparam int NB = 4;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic        kill;
    logic [2:0]  funct3;
    logic [31:0] rs1;
    logic [31:0] rs2;
    logic        busy_a, done_a, busy_b, done_b;
    logic [31:0] result_a;
    logic [15:0] result_b;

    int n_vec = 0;
    int n_err = 0;
    int op_idx = 0;
    logic [31:0] last_res_a;
    logic [15:0] last_res_b;

    muldiv_iter #(.XLEN(32), .BITS_PER_CYCLE(1)) u_dut_a (
        .clock (clk), .reset (rst_n), .start (start), .kill (kill), .funct3 (funct3),
        .rs1 (rs1), .rs2 (rs2), .busy (busy_a), .done (done_a), .result (result_a)
    );

    muldiv_iter #(.XLEN(16), .BITS_PER_CYCLE(4)) u_dut_b (
        .clock (clk), .reset (rst_n), .start (start), .kill (kill), .funct3 (funct3),
        .rs1 (rs1[15:0]), .rs2 (rs2[15:0]), .busy (busy_b), .done (done_b), .result (result_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // RV32M semantics at width w, computed with plain 64-bit arithmetic.
    function automatic logic [31:0] ref_op(input int w, input logic [2:0] f,
                                           input logic [31:0] a_in, input logic [31:0] b_in,
                                           output bit special);
        logic [63:0] mask, a, b, sa, sb, p, r;
        mask = (64'd1 << w) - 64'd1;
        a = {32'd0, a_in} & mask;
        b = {32'd0, b_in} & mask;
        sa = a[w-1] ? (a | ~mask) : a;
        sb = b[w-1] ? (b | ~mask) : b;
        special = 1'b0;
        r = '0;
        case (f)
            3'd0: begin p = a * b;   r = p & mask; end
            3'd1: begin p = sa * sb; r = (p >> w) & mask; end
            3'd2: begin p = sa * b;  r = (p >> w) & mask; end
            3'd3: begin p = a * b;   r = (p >> w) & mask; end
            3'd4, 3'd6: begin
                if (b == 64'd0) begin
                    special = 1'b1;
                    r = (f == 3'd4) ? mask : a;
                end else if (a == (64'd1 << (w - 1)) && b == mask) begin
                    special = 1'b1;
                    r = (f == 3'd4) ? a : 64'd0;
                end else if (f == 3'd4) begin
                    r = 64'($signed(sa) / $signed(sb)) & mask;
                end else begin
                    r = 64'($signed(sa) % $signed(sb)) & mask;
                end
            end
            3'd5, 3'd7: begin
                if (b == 64'd0) begin
                    special = 1'b1;
                    r = (f == 3'd5) ? mask : a;
                end else begin
                    r = (f == 3'd5) ? (a / b) : (a % b);
                end
            end
            default: r = '0;
        endcase
        return r[31:0];
    endfunction

    // Called at the negedge after the accepting edge; cycle 1 is sampled immediately.
    task automatic monitor(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b, input int inj);
        int cyc = 1;
        int lat_a = -1, lat_b = -1, bsy_a = 0, bsy_b = 0;
        bit sp_a, sp_b;
        logic [31:0] ea, eb;
        while ((lat_a < 0 || lat_b < 0) && cyc <= 100) begin
            if (lat_a < 0) begin
                if (busy_a) bsy_a++;
                if (done_a) begin lat_a = cyc; last_res_a = result_a; end
            end
            if (lat_b < 0) begin
                if (busy_b) bsy_b++;
                if (done_b) begin lat_b = cyc; last_res_b = result_b; end
            end
            start = (cyc == inj);
            if (start) begin
                funct3 = 3'($urandom_range(0, 7));
                rs1 = $urandom;
                rs2 = $urandom;
            end
            if (lat_a < 0 || lat_b < 0) begin
                @(negedge clk);
                cyc++;
            end
        end
        start = 1'b0;
        ea = ref_op(32, f, a, b, sp_a);
        eb = ref_op(16, f, a, b, sp_b);
        check($sformatf("res_a#%0d", op_idx), {32'd0, last_res_a}, {32'd0, ea});
        check($sformatf("res_b#%0d", op_idx), {48'd0, last_res_b}, {48'd0, eb[15:0]});
        check($sformatf("lat_a#%0d", op_idx), 64'(lat_a), 64'(sp_a ? 1 : NA + 1));
        check($sformatf("lat_b#%0d", op_idx), 64'(lat_b), 64'(sp_b ? 1 : NB + 1));
        check($sformatf("busy_a#%0d", op_idx), 64'(bsy_a), 64'(sp_a ? 0 : NA));
        check($sformatf("busy_b#%0d", op_idx), 64'(bsy_b), 64'(sp_b ? 0 : NB));
        @(negedge clk);
        check($sformatf("done_pulse#%0d", op_idx), {62'd0, done_a, done_b}, 64'd0);
        $display("op %0d f=%0d a=%h b=%h -> a:%h (lat %0d) b:%h (lat %0d)",
                 op_idx, f, a, b, last_res_a, lat_a, last_res_b, lat_b);
        op_idx++;
    endtask

    task automatic run_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b, input int inj);
        start = 1'b1; funct3 = f; rs1 = a; rs2 = b;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        monitor(f, a, b, inj);
    endtask

    logic [2:0]  plan_f   [12] = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd6, 3'd5, 3'd7,
                                   3'd5, 3'd6, 3'd4, 3'd6};
    logic [31:0] plan_a   [12] = '{32'd7, 32'h80000000, 32'hFFFFFFFF, 32'hFFFFFFFF,
                                   32'hFFFFFFF9, 32'hFFFFFFF9, 32'hFFFFFFF9, 32'hFFFFFFF9,
                                   32'd5, 32'd5, 32'h80000000, 32'h80000000};
    logic [31:0] plan_b   [12] = '{32'hFFFFFFFD, 32'h80000000, 32'hFFFFFFFF, 32'hFFFFFFFF,
                                   32'd2, 32'd2, 32'd2, 32'd2,
                                   32'd0, 32'd0, 32'hFFFFFFFF, 32'hFFFFFFFF};
    logic [31:0] plan_exp [12] = '{32'hFFFFFFEB, 32'h40000000, 32'hFFFFFFFF, 32'hFFFFFFFE,
                                   32'hFFFFFFFD, 32'hFFFFFFFF, 32'h7FFFFFFC, 32'd1,
                                   32'hFFFFFFFF, 32'd5, 32'h80000000, 32'd0};

    initial begin
        int seen;
        logic [2:0]  rf;
        logic [31:0] ra, rb;
        rst_n = 1'b0; start = 1'b0; kill = 1'b0; funct3 = '0; rs1 = '0; rs2 = '0;
        repeat (3) @(negedge clk);
        check("reset_a", {30'd0, busy_a, done_a, result_a}, 64'd0);
        check("reset_b", {46'd0, busy_b, done_b, result_b}, 64'd0);
        rst_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 12; i++) begin
            run_op(plan_f[i], plan_a[i], plan_b[i], 0);
            check($sformatf("plan%0d", i), {32'd0, last_res_a}, {32'd0, plan_exp[i]});
        end

        // kill and start together: nothing accepted
        start = 1'b1; kill = 1'b1; funct3 = 3'd0; rs1 = 32'd3; rs2 = 32'd4;
        @(negedge clk);
        start = 1'b0; kill = 1'b0;
        check("kill_start", {60'd0, busy_a, done_a, busy_b, done_b}, 64'd0);
        $display("kill+start same cycle: busy_a=%b done_a=%b", busy_a, done_a);

        // kill at cycle 10 of a DIV
        start = 1'b1; funct3 = 3'd4; rs1 = 32'h12345678; rs2 = 32'd7;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (9) @(negedge clk);
        kill = 1'b1;
        @(negedge clk);
        kill = 1'b0;
        check("kill_busy", {63'd0, busy_a}, 64'd0);
        seen = 0;
        repeat (40) begin
            if (done_a) seen++;
            @(negedge clk);
        end
        check("kill_no_done", 64'(seen), 64'd0);
        $display("kill at cycle 10: busy_a=%b, dones after kill=%0d", busy_a, seen);

        // stray start mid-op must not disturb captured operands
        run_op(3'd5, 32'h9ABC1234, 32'h00030007, 3);
        run_op(3'd0, 32'd3, 32'd4, 0);
        check("mul_3x4", {32'd0, last_res_a}, 64'd12);

        // asynchronous reset mid-MULHU
        start = 1'b1; funct3 = 3'd3; rs1 = 32'hDEADBEEF; rs2 = 32'hCAFEF00D;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("rst_async_a", {30'd0, busy_a, done_a, result_a}, 64'd0);
        check("rst_async_b", {46'd0, busy_b, done_b, result_b}, 64'd0);
        $display("async reset mid-op: busy_a=%b done_a=%b result_a=%h", busy_a, done_a, result_a);
        @(negedge clk);
        rst_n = 1'b1;
        seen = 0;
        repeat (40) begin
            if (done_a || done_b) seen++;
            @(negedge clk);
        end
        check("rst_no_done", 64'(seen), 64'd0);

        // back-to-back: special op, then a new start in its DONE cycle
        start = 1'b1; funct3 = 3'd5; rs1 = 32'd5; rs2 = 32'd0;
        @(posedge clk);
        @(negedge clk);
        check("b2b_first", {30'd0, done_a, done_b, result_a}, {30'd0, 2'b11, 32'hFFFFFFFF});
        $display("b2b first: done_a=%b result_a=%h", done_a, result_a);
        ra = $urandom; rb = $urandom;
        funct3 = 3'd0; rs1 = ra; rs2 = rb;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        monitor(3'd0, ra, rb, 0);

        for (int i = 0; i < 30; i++) begin
            rf = 3'($urandom_range(0, 7));
            ra = $urandom;
            rb = $urandom;
            case ($urandom_range(0, 7))
                0: rb = 32'd0;
                1: begin ra = 32'h80008000; rb = 32'hFFFFFFFF; end
                default: ;
            endcase
            run_op(rf, ra, rb, 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
